axis_packet_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream output (the UART/console TX stream) between `NUM_SOURCES` packet producers such as the GPIO-to-ASCII message generators. A grant is held for a whole packet, from first beat to the accepted `tlast` beat. After each packet the arbiter inserts a fixed idle gap. It also checks each packet's beat count against the length carried in `tuser`.

---
 rtl/axis_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/axis_packet_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter family.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 (mod N)
// and returns the first requester as a one-hot vector and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        int cand;
        cand    = 0;
        gnt     = '0;
        gnt_idx = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % N;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter with post-packet idle gap and
// beat-count versus tuser length checking.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 12,
    parameter int GAP_CYCLES  = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_SOURCES-1:0]            s_axis_valid,
    input  logic [NUM_SOURCES-1:0]            s_axis_last,
    input  logic [NUM_SOURCES*USER_WIDTH-1:0] s_axis_tuser,
    output logic [NUM_SOURCES-1:0]            s_axis_ready,
    output logic [DATA_WIDTH-1:0]             m_axis_data,
    output logic                              m_axis_valid,
    output logic                              m_axis_last,
    output logic [USER_WIDTH-1:0]             m_axis_tuser,
    input  logic                              m_axis_ready,
    output logic [$clog2(NUM_SOURCES)-1:0]    grant_idx,
    output logic                              busy,
    output logic                              len_err
);

    localparam int IW = idx_width(NUM_SOURCES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [DATA_WIDTH-1:0] src_data  [NUM_SOURCES];
    logic [USER_WIDTH-1:0] src_tuser [NUM_SOURCES];

    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
        assign src_data[gi]  = s_axis_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign src_tuser[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
    end

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic [NUM_SOURCES-1:0] grant_oh_q, grant_oh_d;
    logic [USER_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [USER_WIDTH-1:0]  exp_len_q, exp_len_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic                   len_err_q, len_err_d;

    logic [NUM_SOURCES-1:0] arb_gnt;
    logic [IW-1:0]          arb_idx;

    rr_arbiter #(
        .N  (NUM_SOURCES),
        .IW (IW)
    ) u_rr (
        .req        (s_axis_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    // The data path is a pure mux off registered state, so reset clears it at once.
    logic in_send;
    assign in_send = (state_q == SEND);

    always_comb begin
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        m_axis_tuser = '0;
        s_axis_ready = '0;
        if (in_send) begin
            m_axis_data  = src_data[grant_q];
            m_axis_valid = s_axis_valid[grant_q];
            m_axis_last  = s_axis_last[grant_q];
            m_axis_tuser = src_tuser[grant_q];
            s_axis_ready = grant_oh_q & {NUM_SOURCES{m_axis_ready}};
        end
    end

    logic                  fire;
    logic [USER_WIDTH-1:0] beat_inc;
    logic [USER_WIDTH-1:0] len_ref;

    assign fire     = m_axis_valid & m_axis_ready;
    assign beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
    // A one-beat packet has not latched exp_len yet; use its own tuser.
    assign len_ref  = (beat_cnt_q == '0) ? m_axis_tuser : exp_len_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        grant_oh_d   = grant_oh_q;
        beat_cnt_d   = beat_cnt_q;
        exp_len_d    = exp_len_q;
        gap_cnt_d    = gap_cnt_q;
        len_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|s_axis_valid) begin
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    grant_oh_d   = arb_gnt;
                    beat_cnt_d   = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    if (beat_cnt_q == '0) begin
                        exp_len_d = m_axis_tuser;
                    end
                    if (m_axis_last) begin
                        len_err_d  = (beat_inc != len_ref);
                        beat_cnt_d = '0;
                        gap_cnt_d  = '0;
                        state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_SOURCES - 1);
            grant_oh_q   <= '0;
            beat_cnt_q   <= '0;
            exp_len_q    <= '0;
            gap_cnt_q    <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            grant_oh_q   <= grant_oh_d;
            beat_cnt_q   <= beat_cnt_d;
            exp_len_q    <= exp_len_d;
            gap_cnt_q    <= gap_cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: one instance with a 5-cycle gap and
// one with no gap, selected onto a shared source model and monitor.
module tb_axis_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [3:0]  s_valid;
    logic [3:0]  s_last;
    logic [47:0] s_tuser;
    logic        m_ready;
    logic        sel;

    always #5 clk = ~clk;

    logic [3:0]  a_sv, b_sv, a_sr, b_sr;
    logic [7:0]  a_md, b_md;
    logic        a_mv, b_mv, a_ml, b_ml, a_busy, b_busy, a_le, b_le;
    logic [11:0] a_mu, b_mu;
    logic [1:0]  a_gi, b_gi;

    assign a_sv = s_valid & {4{~sel}};
    assign b_sv = s_valid & {4{sel}};

    axis_packet_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(8), .USER_WIDTH(12), .GAP_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(a_sv), .s_axis_last(s_last),
        .s_axis_tuser(s_tuser), .s_axis_ready(a_sr), .m_axis_data(a_md), .m_axis_valid(a_mv),
        .m_axis_last(a_ml), .m_axis_tuser(a_mu), .m_axis_ready(m_ready), .grant_idx(a_gi),
        .busy(a_busy), .len_err(a_le));

    axis_packet_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(8), .USER_WIDTH(12), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(b_sv), .s_axis_last(s_last),
        .s_axis_tuser(s_tuser), .s_axis_ready(b_sr), .m_axis_data(b_md), .m_axis_valid(b_mv),
        .m_axis_last(b_ml), .m_axis_tuser(b_mu), .m_axis_ready(m_ready), .grant_idx(b_gi),
        .busy(b_busy), .len_err(b_le));

    logic [3:0] sready;
    logic [7:0] mdata;
    logic       mv, ml, busy, lerr;
    logic [1:0] gidx;

    assign sready = sel ? b_sr : a_sr;
    assign mdata  = sel ? b_md : a_md;
    assign mv     = sel ? b_mv : a_mv;
    assign ml     = sel ? b_ml : a_ml;
    assign busy   = sel ? b_busy : a_busy;
    assign lerr   = sel ? b_le : a_le;
    assign gidx   = sel ? b_gi : a_gi;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Source model: each source holds a count of queued packets of equal length.
    int          src_pkts [4];
    int          src_len  [4];
    int          src_beat [4];
    logic [11:0] src_tu   [4];
    logic [3:0]  fire_r;
    logic        rdy_toggle;
    int          cyc;

    // Monitor records
    int beat_data [64];
    int pkt_src   [16];
    int pkt_gidx  [16];
    int pkt_first [16];
    int pkt_last  [16];
    int pkt_beats [16];
    int nbeats, npk, busy_cnt, rdy_viol, lerr_cnt, lerr_cyc, last_cnt, cur_beats;
    logic in_pkt;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_valid[i]            = (src_pkts[i] > 0);
            s_data[i*8 +: 8]      = 8'(i*16 + src_beat[i]);
            s_last[i]             = (src_beat[i] == src_len[i] - 1);
            s_tuser[i*12 +: 12]   = src_tu[i];
        end
        m_ready = rdy_toggle ? ~cyc[0] : 1'b1;
    endtask

    task automatic monitor();
        fire_r = s_valid & sready;
        if (busy) busy_cnt++;
        for (int i = 0; i < 4; i++)
            if (sready[i] && (!busy || int'(gidx) != i)) rdy_viol++;
        if (lerr) begin
            lerr_cnt++;
            lerr_cyc = cyc;
        end
        if (mv && m_ready) begin
            if (nbeats < 64) beat_data[nbeats] = int'(mdata);
            nbeats++;
            cur_beats++;
            if (ml) last_cnt++;
            if (!in_pkt && npk < 16) begin
                pkt_src[npk]   = int'(mdata) / 16;
                pkt_gidx[npk]  = int'(gidx);
                pkt_first[npk] = cyc;
                in_pkt = 1'b1;
            end
            if (ml && npk < 16) begin
                pkt_last[npk]  = cyc;
                pkt_beats[npk] = cur_beats;
                cur_beats = 0;
                npk++;
                in_pkt = 1'b0;
            end
        end
    endtask

    task automatic advance();
        for (int i = 0; i < 4; i++) begin
            if (fire_r[i]) begin
                src_beat[i]++;
                if (src_beat[i] == src_len[i]) begin
                    src_beat[i] = 0;
                    src_pkts[i]--;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        advance();
        cyc++;
        drive();
    endtask

    task automatic clear_stats();
        nbeats = 0; npk = 0; busy_cnt = 0; rdy_viol = 0; lerr_cnt = 0;
        lerr_cyc = -1; last_cnt = 0; cur_beats = 0; in_pkt = 1'b0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 4; i++) begin
            src_pkts[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_tu[i] = '0;
        end
    endtask

    task automatic load(input int src, input int pkts, input int len, input int tu);
        src_pkts[src] = pkts;
        src_len[src]  = len;
        src_beat[src] = 0;
        src_tu[src]   = 12'(tu);
        drive();
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        while (((src_pkts[0] + src_pkts[1] + src_pkts[2] + src_pkts[3]) > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check_val({tag, "_timeout"}, 32'(n < budget), 32'd1);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        rst = 1'b1; sel = 1'b0; rdy_toggle = 1'b0; cyc = 0;
        s_valid = '0; s_data = '0; s_last = '0; s_tuser = '0; m_ready = 1'b1;
        clear_sources();
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_m_valid", 32'(mv), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_grant_idx", 32'(gidx), 32'd0);
        check_val("rst_s_ready", 32'(sready), 32'd0);
        check_val("rst_len_err", 32'(lerr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive();

        // Single 5-beat packet from source 0
        clear_stats();
        t0 = cyc;
        load(0, 1, 5, 5);
        run("t2", 100);
        check_val("t2_npk", 32'(npk), 32'd1);
        check_val("t2_beats", 32'(nbeats), 32'd5);
        for (int i = 0; i < 5; i++) check_val("t2_data", 32'(beat_data[i]), 32'(i));
        check_val("t2_last_cnt", 32'(last_cnt), 32'd1);
        check_val("t2_last_on_5", 32'(pkt_last[0] - pkt_first[0]), 32'd4);
        check_val("t2_latency", 32'(pkt_first[0] - t0), 32'd1);
        check_val("t2_len_err", 32'(lerr_cnt), 32'd0);
        check_val("t2_busy_cycles", 32'(busy_cnt), 32'd10);
        check_val("t2_grant", 32'(pkt_gidx[0]), 32'd0);

        // All four sources: rotation 0,1,2,3,0 after a fresh reset
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        clear_stats();
        load(0, 2, 3, 3);
        load(1, 1, 3, 3);
        load(2, 1, 3, 3);
        load(3, 1, 3, 3);
        run("t3", 400);
        check_val("t3_npk", 32'(npk), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check_val("t3_order", 32'(pkt_src[k]), 32'(k % 4));
            check_val("t3_gidx", 32'(pkt_gidx[k]), 32'(k % 4));
            check_val("t3_pkt_beats", 32'(pkt_beats[k]), 32'd3);
        end
        for (int k = 1; k < 5; k++)
            check_val("t3_spacing", 32'(pkt_first[k] - pkt_last[k-1]), 32'd7);
        check_val("t3_ready_excl", 32'(rdy_viol), 32'd0);

        // Backpressure toggling during a 5-beat packet from source 1
        clear_stats();
        rdy_toggle = 1'b1;
        load(1, 1, 5, 5);
        run("t4", 100);
        rdy_toggle = 1'b0;
        drive();
        check_val("t4_beats", 32'(nbeats), 32'd5);
        for (int i = 0; i < 5; i++) check_val("t4_data", 32'(beat_data[i]), 32'(16 + i));
        check_val("t4_src", 32'(pkt_src[0]), 32'd1);
        check_val("t4_ready_excl", 32'(rdy_viol), 32'd0);
        check_val("t4_len_err", 32'(lerr_cnt), 32'd0);

        // Length mismatch on source 2, then normal packet from source 3
        clear_stats();
        load(2, 1, 4, 6);
        load(3, 1, 3, 3);
        run("t5", 200);
        check_val("t5_npk", 32'(npk), 32'd2);
        check_val("t5_src0", 32'(pkt_src[0]), 32'd2);
        check_val("t5_src1", 32'(pkt_src[1]), 32'd3);
        check_val("t5_len_err_cnt", 32'(lerr_cnt), 32'd1);
        check_val("t5_len_err_cyc", 32'(lerr_cyc - pkt_last[0]), 32'd1);
        check_val("t5_next_beats", 32'(pkt_beats[1]), 32'd3);

        // One-beat packets: tuser 1 is correct, tuser 2 is an error
        clear_stats();
        load(0, 1, 1, 1);
        load(1, 1, 1, 2);
        run("t5b", 200);
        check_val("t5b_npk", 32'(npk), 32'd2);
        check_val("t5b_src0", 32'(pkt_src[0]), 32'd0);
        check_val("t5b_len_err_cnt", 32'(lerr_cnt), 32'd1);
        check_val("t5b_len_err_cyc", 32'(lerr_cyc - pkt_last[1]), 32'd1);

        // Asynchronous reset after beat 2 of a 5-beat packet
        clear_stats();
        load(2, 1, 5, 5);
        n = 0;
        while (nbeats < 2 && n < 20) begin
            step();
            n++;
        end
        check_val("t6_reach_beat2", 32'(nbeats), 32'd2);
        check_val("t6_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_m_valid", 32'(mv), 32'd0);
        check_val("t6_s_ready", 32'(sready), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_grant_idx", 32'(gidx), 32'd0);
        check_val("t6_m_data", 32'(mdata), 32'd0);
        clear_sources();
        drive();
        @(posedge clk);
        #1 rst = 1'b0;
        clear_stats();
        load(2, 1, 2, 2);
        load(0, 1, 2, 2);
        run("t6", 200);
        check_val("t6_first_src", 32'(pkt_src[0]), 32'd0);
        check_val("t6_second_src", 32'(pkt_src[1]), 32'd2);

        // Zero-gap instance: sources 1 and 3 alternate 1,3,1
        sel = 1'b1;
        clear_stats();
        load(1, 2, 2, 2);
        load(3, 1, 2, 2);
        run("t7", 200);
        check_val("t7_npk", 32'(npk), 32'd3);
        check_val("t7_order0", 32'(pkt_src[0]), 32'd1);
        check_val("t7_order1", 32'(pkt_src[1]), 32'd3);
        check_val("t7_order2", 32'(pkt_src[2]), 32'd1);
        for (int k = 1; k < 3; k++)
            check_val("t7_spacing", 32'(pkt_first[k] - pkt_last[k-1]), 32'd2);
        check_val("t7_len_err", 32'(lerr_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
